// File: rtl/seven_seg_scanner_if.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner_if
// Groups the display-register side and the pin side of the seven-segment
// scanner into one bundle.
//
//   i_value      [4*N_DIGITS] hex nibbles, digit k = bits [4k+3:4k], digit 0 rightmost
//   i_dot        [N_DIGITS]   decimal point per digit, 1 = lit
//   i_load                    request capture of i_value/i_dot at next frame boundary
//   i_blank_lz                leading-zero blanking enable
//   i_bright     [3]          duty level 0..7
//   i_blink_en                blink enable
//   o_hex_out    [8]          active-low segments, bit0 = a .. bit6 = g, bit7 = DP
//   o_seg_select [N_DIGITS]   active-low digit enables, bit k = digit k
//   o_frame_done              one-cycle pulse per completed frame
//
// master: the side that owns the display register (drives i_*, observes o_*).
// slave : the scanner itself.
// -----------------------------------------------------------------------------
interface seven_seg_scanner_if #(
  parameter int N_DIGITS = 4
) ();

  logic [4*N_DIGITS-1:0] i_value;
  logic [N_DIGITS-1:0]   i_dot;
  logic                  i_load;
  logic                  i_blank_lz;
  logic [2:0]            i_bright;
  logic                  i_blink_en;
  logic [7:0]            o_hex_out;
  logic [N_DIGITS-1:0]   o_seg_select;
  logic                  o_frame_done;

  modport master (
    output i_value,
    output i_dot,
    output i_load,
    output i_blank_lz,
    output i_bright,
    output i_blink_en,
    input  o_hex_out,
    input  o_seg_select,
    input  o_frame_done
  );

  modport slave (
    input  i_value,
    input  i_dot,
    input  i_load,
    input  i_blank_lz,
    input  i_bright,
    input  i_blink_en,
    output o_hex_out,
    output o_seg_select,
    output o_frame_done
  );

endinterface

// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
// Time-multiplexes N_DIGITS hex digits onto one shared active-low segment bus.
// Features: per-digit decimal points, frame-synchronous value loading,
// leading-zero blanking, 8-level PWM brightness and whole-display blink.
//
// Parameters
//   N_DIGITS     number of digits, 1..8
//   DIV_MAX      clock cycles per digit slot minus 1 (>= 7)
//   DIV_WIDTH    prescaler width, DIV_MAX must fit
//   BLINK_FRAMES scan frames per blink half-period (>= 1)
//
// Ports
//   i_clk   system clock, rising edge
//   i_rst   asynchronous active-high reset
//   io_bus  seven_seg_scanner_if.slave (display inputs, segment/digit outputs)
//
// Pipeline: the prescaler/index/shadow state is decoded combinationally and
// registered into the outputs, so the pins lag the scan state by one cycle.
// The frame-done pulse is delayed by the same amount so it lines up with the
// first cycle in which digit 0 of the new frame is on the pins.
// -----------------------------------------------------------------------------
module seven_seg_scanner #(
  parameter int N_DIGITS     = 4,
  parameter int DIV_MAX      = 99999,
  parameter int DIV_WIDTH    = 17,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  seven_seg_scanner_if.slave   io_bus
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int SLICE = (DIV_MAX + 1) >> 3;
  // Wide enough for SLICE * 8 even when DIV_MAX+1 fills DIV_WIDTH.
  localparam int THR_W = DIV_WIDTH + 4;

  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(DIV_MAX);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [FRM_W-1:0]     FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [THR_W-1:0]     SLICE_T  = THR_W'(SLICE);

  // Active-low hex decode, bit7 (DP) left dark.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      4'hF:    seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  // Scan state
  logic [DIV_WIDTH-1:0]  r_presc;
  logic [IDX_W-1:0]      r_idx;
  logic [FRM_W-1:0]      r_frm;
  logic                  r_phase;
  logic                  r_pending;
  logic [4*N_DIGITS-1:0] r_value;
  logic [N_DIGITS-1:0]   r_dots;

  // Output registers
  logic [7:0]            r_hex;
  logic [N_DIGITS-1:0]   r_sel;
  logic                  r_bnd_d;
  logic                  r_frame_done;

  // Decode nets
  logic                  w_tick;
  logic                  w_boundary;
  logic [N_DIGITS-1:0]   w_onehot;
  logic [3:0]            w_nibble;
  logic                  w_dot;
  logic [N_DIGITS:0]     w_chain;
  logic [THR_W-1:0]      w_thresh;
  logic                  w_bright_ok;
  logic                  w_en;
  logic [N_DIGITS-1:0]   w_lit;
  logic [N_DIGITS-1:0]   w_sel;
  logic [7:0]            w_hex;

  assign w_tick     = (r_presc == DIV_LAST);
  assign w_boundary = w_tick && (r_idx == IDX_LAST);

  // Select the nibble and dot of the digit currently being scanned.
  always_comb begin
    w_onehot = '0;
    w_nibble = 4'h0;
    w_dot    = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      w_onehot[k] = (r_idx == IDX_W'(k));
      w_nibble    = w_nibble | (w_onehot[k] ? r_value[4*k +: 4] : 4'h0);
      w_dot       = w_dot | (w_onehot[k] & r_dots[k]);
    end
  end

  // Leading-zero blanking: a digit is blanked only if every digit above it is
  // blanked too, so the chain is seeded with 1 above the top digit and walks
  // downwards. Digit 0 is forced visible.
  always_comb begin
    w_chain           = '0;
    w_chain[N_DIGITS] = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      w_chain[k] = (k != 0) && io_bus.i_blank_lz && (r_value[4*k +: 4] == 4'h0)
                   && !r_dots[k] && w_chain[k+1];
    end
  end

  // Brightness window, blink gating and segment pattern for the current slot.
  always_comb begin
    w_thresh    = SLICE_T * (THR_W'(io_bus.i_bright) + THR_W'(1));
    w_bright_ok = (THR_W'(r_presc) < w_thresh);
    w_en        = w_bright_ok && !(io_bus.i_blink_en && r_phase);
    w_lit       = w_onehot & ~w_chain[N_DIGITS-1:0] & {N_DIGITS{w_en}};
    w_sel       = ~w_lit;
    w_hex       = hex_to_seg(w_nibble) & ~{w_dot, 7'h00};
  end

  // Prescaler, digit index, blink frame counter and frame-synchronous load.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc   <= '0;
      r_idx     <= '0;
      r_frm     <= '0;
      r_phase   <= 1'b0;
      r_pending <= 1'b0;
      r_value   <= '0;
      r_dots    <= '0;
    end else begin
      if (w_tick) begin
        r_presc <= '0;
        if (r_idx == IDX_LAST) begin
          r_idx <= '0;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end else begin
        r_presc <= r_presc + DIV_WIDTH'(1);
      end

      // The blink counter runs whether or not blink is enabled so that
      // enabling it never restarts the blink rhythm.
      if (w_boundary) begin
        if (r_frm == FRM_LAST) begin
          r_frm   <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_frm <= r_frm + FRM_W'(1);
        end
      end

      // A LOAD in the boundary cycle itself counts; any number of earlier
      // LOADs collapse into one capture of the boundary-cycle inputs.
      if (w_boundary && (r_pending || io_bus.i_load)) begin
        r_value   <= io_bus.i_value;
        r_dots    <= io_bus.i_dot;
        r_pending <= 1'b0;
      end else if (io_bus.i_load) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Output registers; reset drives the pins dark without waiting for a clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hex        <= 8'hFF;
      r_sel        <= '1;
      r_bnd_d      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_hex        <= w_hex;
      r_sel        <= w_sel;
      r_bnd_d      <= w_boundary;
      r_frame_done <= r_bnd_d;
    end
  end

  assign io_bus.o_hex_out    = r_hex;
  assign io_bus.o_seg_select = r_sel;
  assign io_bus.o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scanner
// Directed bench for seven_seg_scanner. Main DUT: 4 digits, 8-cycle slots,
// 2-frame blink half-period. Second DUT: 16-cycle slots for duty counting.
// Expected per-slot digit enables and segment codes are queued when a value
// is loaded and compared cycle by cycle once the frame appears on the pins.
// -----------------------------------------------------------------------------
module tb_seven_seg_scanner;

  localparam int N  = 4;
  localparam int DM = 7;
  localparam int BF = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seven_seg_scanner_if #(.N_DIGITS(N)) bus  ();
  seven_seg_scanner_if #(.N_DIGITS(N)) bus2 ();

  seven_seg_scanner #(
    .N_DIGITS(N), .DIV_MAX(DM), .DIV_WIDTH(3), .BLINK_FRAMES(BF)
  ) dut (
    .i_clk(clk), .i_rst(rst), .io_bus(bus)
  );

  seven_seg_scanner #(
    .N_DIGITS(N), .DIV_MAX(15), .DIV_WIDTH(4), .BLINK_FRAMES(BF)
  ) dut2 (
    .i_clk(clk), .i_rst(rst), .io_bus(bus2)
  );

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] hex;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   tb_frames;

  // Count completed frames since reset to know the blink phase of each frame.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_frames <= 0;
    else if (bus.o_frame_done === 1'b1) tb_frames <= tb_frames + 1;
  end

  function automatic logic [7:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  4'hF: return 8'h8E;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue one expected slot per digit for value v; 'blanked' marks digits
  // whose enable must stay high for the whole slot.
  task automatic push_value(input logic [15:0] v, input logic [3:0] dots,
                            input logic [3:0] blanked);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.hex = seg7(v[4*k +: 4]) & ~{dots[k], 7'h00};
      e.sel = blanked[k] ? 4'hF : ~(4'b0001 << k);
      sb.push_back(e);
    end
  endtask

  task automatic wait_fd(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.o_frame_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_fd_wait"}, 32'(found), 32'd1);
  endtask

  // Called on the frame_done cycle; checks the 32 cycles of one frame.
  task automatic check_scan(input string tag);
    exp_t       e;
    int         m;
    bit         boff;
    logic [3:0] es;
    m    = tb_frames + 1;
    boff = (bus.i_blink_en === 1'b1) && (((m / 2) % 2) == 1);
    check({tag, "_sb_depth"}, 32'(sb.size()), 32'd4);
    if (sb.size() < 4) return;
    for (int k = 0; k < N; k++) begin
      e = sb.pop_front();
      for (int c = 0; c <= DM; c++) begin
        es = (!boff && (c < (int'(bus.i_bright) + 1))) ? e.sel : 4'hF;
        check({tag, "_sel"}, 32'(bus.o_seg_select), 32'(es));
        if (es != 4'hF) check({tag, "_hex"}, 32'(bus.o_hex_out), 32'(e.hex));
        check({tag, "_fdone"}, 32'(bus.o_frame_done), 32'((k == 0) && (c == 0)));
        if (!((k == N - 1) && (c == DM))) @(negedge clk);
      end
    end
  endtask

  task automatic load_frame(input string tag, input logic [15:0] v,
                            input logic [3:0] d, input logic [3:0] blanked);
    wait_fd(tag);
    bus.i_value = v;
    bus.i_dot   = d;
    bus.i_load  = 1'b1;
    @(negedge clk);
    bus.i_load  = 1'b0;
    push_value(v, d, blanked);
    wait_fd(tag);
    check_scan(tag);
  endtask

  // Count enabled cycles over one 64-cycle frame of the 16-cycle-slot DUT.
  task automatic duty2(input string tag, input logic [2:0] b, input int exp_low);
    bit found = 1'b0;
    int cnt   = 0;
    bus2.i_bright = b;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus2.o_frame_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_fd_wait"}, 32'(found), 32'd1);
    for (int c = 0; c < 64; c++) begin
      if (bus2.o_seg_select !== 4'hF) cnt++;
      @(negedge clk);
    end
    check({tag, "_low_cycles"}, 32'(cnt), 32'(exp_low));
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    bus.i_value = 16'h0000;  bus.i_dot = 4'h0;  bus.i_load = 1'b0;
    bus.i_blank_lz = 1'b0;   bus.i_bright = 3'd7; bus.i_blink_en = 1'b0;
    bus2.i_value = 16'h0000; bus2.i_dot = 4'h0; bus2.i_load = 1'b0;
    bus2.i_blank_lz = 1'b0;  bus2.i_bright = 3'd7; bus2.i_blink_en = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_hex", 32'(bus.o_hex_out), 32'hFF);
    check("rst_sel", 32'(bus.o_seg_select), 32'hF);
    check("rst_fdone", 32'(bus.o_frame_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("first_sel", 32'(bus.o_seg_select), 32'hE);
    check("first_hex", 32'(bus.o_hex_out), 32'hC0);
    push_value(16'h0000, 4'h0, 4'h0);
    wait_fd("init");
    check_scan("init");

    // Basic scan
    load_frame("basic", 16'h1234, 4'h0, 4'h0);

    // Load sync: request 00A5, then change inputs to FFFF before the boundary
    wait_fd("sync");
    repeat (3) @(negedge clk);
    bus.i_value = 16'h00A5;
    bus.i_load  = 1'b1;
    @(negedge clk);
    bus.i_load  = 1'b0;
    repeat (5) @(negedge clk);
    bus.i_value = 16'hFFFF;
    sb.push_back('{sel: 4'hD, hex: 8'hB0});
    e = sb.pop_front();
    check("sync_old_sel", 32'(bus.o_seg_select), 32'(e.sel));
    check("sync_old_hex", 32'(bus.o_hex_out), 32'(e.hex));
    push_value(16'hFFFF, 4'h0, 4'h0);
    wait_fd("sync");
    check_scan("sync");

    // Leading-zero blanking
    bus.i_blank_lz = 1'b1;
    load_frame("blz_a",    16'h0005, 4'b0000, 4'b1110);
    load_frame("blz_dot",  16'h0005, 4'b0100, 4'b1000);
    load_frame("blz_zero", 16'h0000, 4'b0000, 4'b1110);
    bus.i_blank_lz = 1'b0;

    // Brightness
    bus.i_bright = 3'd0;
    load_frame("bri0", 16'h1234, 4'h0, 4'h0);
    bus.i_bright = 3'd3;
    load_frame("bri3", 16'h9A7F, 4'b1001, 4'h0);
    bus.i_bright = 3'd7;
    duty2("duty_b0", 3'd0, 8);
    duty2("duty_b3", 3'd3, 32);
    duty2("duty_b7", 3'd7, 64);

    // Blink
    bus.i_blink_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      push_value(16'h9A7F, 4'b1001, 4'h0);
      wait_fd("blink");
      check_scan("blink");
    end
    bus.i_blink_en = 1'b0;
    for (int f = 0; f < 2; f++) begin
      push_value(16'h9A7F, 4'b1001, 4'h0);
      wait_fd("noblink");
      check_scan("noblink");
    end

    // Reset mid-slot with a LOAD pending
    wait_fd("mid_rst");
    bus.i_value = 16'h9999;
    bus.i_load  = 1'b1;
    @(negedge clk);
    bus.i_load  = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_hex", 32'(bus.o_hex_out), 32'hFF);
    check("mid_rst_sel", 32'(bus.o_seg_select), 32'hF);
    check("mid_rst_fdone", 32'(bus.o_frame_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_sel", 32'(bus.o_seg_select), 32'hE);
    check("post_rst_hex", 32'(bus.o_hex_out), 32'hC0);
    push_value(16'h0000, 4'h0, 4'h0);
    wait_fd("post_rst");
    check_scan("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
